// File: rtl/flash_ctrl_pkg.sv
// Shared definitions for the parallel NOR flash controller:
// FSM state encoding, flash command bytes and counter sizing.
package flash_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam logic [3:0] S_INIT     = 4'd0;
    localparam logic [3:0] S_IDLE     = 4'd1;
    localparam logic [3:0] S_RD       = 4'd2;
    localparam logic [3:0] S_WR_CMD   = 4'd3;
    localparam logic [3:0] S_WR_GAP   = 4'd4;
    localparam logic [3:0] S_WR_DATA  = 4'd5;
    localparam logic [3:0] S_WAIT_STS = 4'd6;
    localparam logic [3:0] S_WR_RA    = 4'd7;
    localparam logic [3:0] S_FIN      = 4'd8;

    localparam logic [7:0] CMD_PROGRAM    = 8'h40;
    localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;

    // One shared phase counter must reach the longest timed phase.
    function automatic int cnt_width(
        input int a,
        input int b,
        input int c,
        input int d,
        input int e
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        cnt_width = (m < 4) ? 2 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/flash_sync2.sv
// Two-flop synchronizer for the asynchronous flash status line.
module flash_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/flash_ctrl.sv
// Byte read / program controller for an x8 parallel NOR flash.
// All flash pins are registered decodes of the current FSM state.
module flash_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int T_ACC   = 4,
    parameter int T_WP    = 3,
    parameter int T_GAP   = 2,
    parameter int T_RST   = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] NF_A,
    output logic [7:0]        NF_D_OUT,
    output logic              NF_D_OE,
    input  logic [7:0]        NF_D_IN,
    output logic              NF_CE,
    output logic              NF_OE,
    output logic              NF_WE,
    output logic              NF_BYTE,
    output logic              NF_RP,
    output logic              NF_WP,
    input  logic              NF_STS
);

    localparam int CNT_W = cnt_width(T_ACC, T_WP, T_GAP, T_RST, TIMEOUT);

    localparam logic [CNT_W-1:0] C_ACC  = CNT_W'(T_ACC - 1);
    localparam logic [CNT_W-1:0] C_WP   = CNT_W'(T_WP - 1);
    localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] C_RST  = CNT_W'(T_RST - 1);
    localparam logic [CNT_W-1:0] C_TO   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_SKIP = CNT_W'(2);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_err;
    logic              r_gap_to_sts;
    logic              w_timeout;
    logic              w_sts;

    logic              r_nf_rp;
    logic              r_nf_ce;
    logic              r_nf_oe;
    logic              r_nf_we;
    logic              r_nf_d_oe;
    logic [ADDR_W-1:0] r_nf_a;
    logic [7:0]        r_nf_d_out;
    logic              r_done;
    logic [7:0]        r_rdata;

    logic              w_rd;
    logic              w_wr_phase;
    logic              w_we_low;
    logic              w_addr_drv;

    flash_sync2 u_sts_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (NF_STS),
        .o_q   (w_sts)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_cnt == C_RST) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (req) w_state_nxt = we ? S_WR_CMD : S_RD;
            end
            S_RD: begin
                if (r_cnt == C_ACC) w_state_nxt = S_FIN;
            end
            S_WR_CMD: begin
                if (r_cnt == C_WP) w_state_nxt = S_WR_GAP;
            end
            S_WR_GAP: begin
                if (r_cnt == C_GAP)
                    w_state_nxt = r_gap_to_sts ? S_WAIT_STS : S_WR_DATA;
            end
            S_WR_DATA: begin
                if (r_cnt == C_WP) w_state_nxt = S_WR_GAP;
            end
            S_WAIT_STS: begin
                // Status sampled before the program began is stale.
                if ((r_cnt >= C_SKIP) && w_sts) begin
                    w_state_nxt = S_WR_RA;
                end else if (r_cnt == C_TO) begin
                    w_state_nxt = S_WR_RA;
                    w_timeout   = 1'b1;
                end
            end
            S_WR_RA: begin
                if (r_cnt == C_WP) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_INIT;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_gap_to_sts <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || (r_state == S_IDLE))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if ((r_state == S_IDLE) && req) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_err   <= 1'b0;
            end
            if (w_timeout)
                r_err <= 1'b1;
            if (r_state == S_WR_CMD)
                r_gap_to_sts <= 1'b0;
            else if (r_state == S_WR_DATA)
                r_gap_to_sts <= 1'b1;
        end
    end

    assign w_rd       = (r_state == S_RD);
    assign w_wr_phase = (r_state == S_WR_CMD) || (r_state == S_WR_GAP) ||
                        (r_state == S_WR_DATA) || (r_state == S_WR_RA);
    assign w_we_low   = (r_state == S_WR_CMD) || (r_state == S_WR_DATA) ||
                        (r_state == S_WR_RA);
    assign w_addr_drv = w_rd || w_wr_phase || (r_state == S_WAIT_STS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nf_rp    <= 1'b0;
            r_nf_ce    <= 1'b1;
            r_nf_oe    <= 1'b1;
            r_nf_we    <= 1'b1;
            r_nf_d_oe  <= 1'b0;
            r_nf_a     <= '0;
            r_nf_d_out <= '0;
            r_done     <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_nf_rp   <= 1'b1;
            r_nf_ce   <= ~(w_rd | w_wr_phase);
            r_nf_oe   <= ~w_rd;
            r_nf_we   <= ~w_we_low;
            r_nf_d_oe <= w_wr_phase;
            if (w_addr_drv)
                r_nf_a <= r_addr;
            case (r_state)
                S_WR_CMD:  r_nf_d_out <= CMD_PROGRAM;
                S_WR_DATA: r_nf_d_out <= r_wdata;
                S_WR_RA:   r_nf_d_out <= CMD_READ_ARRAY;
                S_WR_GAP:  r_nf_d_out <= r_nf_d_out;
                default:   r_nf_d_out <= '0;
            endcase
            r_done <= (r_state == S_FIN);
            // The FIN cycle is the last one with NF_OE driven low.
            if ((r_state == S_FIN) && !r_we)
                r_rdata <= NF_D_IN;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign err      = r_err;
    assign rdata    = r_rdata;
    assign NF_A     = r_nf_a;
    assign NF_D_OUT = r_nf_d_out;
    assign NF_D_OE  = r_nf_d_oe;
    assign NF_CE    = r_nf_ce;
    assign NF_OE    = r_nf_oe;
    assign NF_WE    = r_nf_we;
    assign NF_RP    = r_nf_rp;
    assign NF_BYTE  = 1'b0;
    assign NF_WP    = 1'b1;

endmodule

// File: tb/tb_flash_ctrl.sv
// Scoreboard bench for flash_ctrl: directed reads and programs
// against a simple flash bus model.
module tb_flash_ctrl;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] NF_A;
    logic [7:0]    NF_D_OUT;
    logic          NF_D_OE;
    logic [7:0]    NF_D_IN;
    logic          NF_CE;
    logic          NF_OE;
    logic          NF_WE;
    logic          NF_BYTE;
    logic          NF_RP;
    logic          NF_WP;
    logic          NF_STS;
    logic [7:0]    rd_val;

    always #5 clk = ~clk;

    flash_ctrl #(
        .ADDR_W  (AW),
        .T_ACC   (4),
        .T_WP    (3),
        .T_GAP   (2),
        .T_RST   (8),
        .TIMEOUT (1000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .NF_A     (NF_A),
        .NF_D_OUT (NF_D_OUT),
        .NF_D_OE  (NF_D_OE),
        .NF_D_IN  (NF_D_IN),
        .NF_CE    (NF_CE),
        .NF_OE    (NF_OE),
        .NF_WE    (NF_WE),
        .NF_BYTE  (NF_BYTE),
        .NF_RP    (NF_RP),
        .NF_WP    (NF_WP),
        .NF_STS   (NF_STS)
    );

    assign NF_D_IN = (!NF_CE && !NF_OE) ? rd_val : 8'h00;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int viol = 0;
    int oe_cnt = 0;
    logic [AW-1:0] oe_addr = '0;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mx;

    int            wlen = 0;
    logic [7:0]    wcur = '0;
    logic [AW-1:0] wacur = '0;
    logic [7:0]    wr_q[$];
    int            wlen_q[$];
    logic [AW-1:0] wadr_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every done pulse consumes one expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt <= done_cnt + 1;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                mx = sb_q.pop_front();
                chk("done_rdata", {24'h0, rdata}, {24'h0, mx.rdata});
                chk("done_err", {31'h0, err}, {31'h0, mx.err});
                if (mx.due >= 0)
                    chk("done_latency", cyc, mx.due);
            end
        end
    end

    // Flash bus model: records every completed write pulse.
    always @(negedge clk) begin
        if (!NF_OE && NF_D_OE) viol <= viol + 1;
        if (!NF_WE && !NF_D_OE) viol <= viol + 1;
        if (!NF_OE) begin
            oe_cnt  <= oe_cnt + 1;
            oe_addr <= NF_A;
        end
        if (rst) begin
            wlen <= 0;
        end else if (!NF_WE && !NF_CE) begin
            wlen  <= wlen + 1;
            wcur  <= NF_D_OUT;
            wacur <= NF_A;
        end else if (wlen > 0) begin
            wr_q.push_back(wcur);
            wlen_q.push_back(wlen);
            wadr_q.push_back(wacur);
            wlen <= 0;
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a,
                         input logic [7:0] d, input logic [7:0] er,
                         input logic ee, input int lat);
        int   t;
        exp_t x;
        t = 0;
        @(negedge clk);
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("issue_idle", {31'h0, busy}, 32'h0);
        x.rdata = er;
        x.err   = ee;
        x.due   = (lat < 0) ? -1 : cyc + lat;
        sb_q.push_back(x);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget, input string name);
        int t;
        t = 0;
        while (done_cnt <= n0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if (done_cnt <= n0) begin
            errors++;
            $display("FAIL %s: got no done within %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic wait_writes(input int n, input int budget);
        int t;
        t = 0;
        while (wr_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int w0;
        int o0;
        int bad;
        int t;
        req    = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        NF_STS = 1'b1;
        rd_val = 8'h00;
        bad    = 0;

        repeat (3) @(negedge clk);
        chk("rst_rp", {31'h0, NF_RP}, 32'h0);
        chk("rst_strobes", {28'h0, NF_CE, NF_OE, NF_WE, NF_D_OE}, 32'hE);
        chk("rst_addr", {8'h0, NF_A}, 32'h0);
        chk("rst_dout", {24'h0, NF_D_OUT}, 32'h0);
        chk("rst_rdata", {24'h0, rdata}, 32'h0);
        chk("rst_done_err", {30'h0, done, err}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("byte_wp", {30'h0, NF_BYTE, NF_WP}, 32'h1);

        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rp_first_cycle", {31'h0, NF_RP}, 32'h1);
        for (int i = 2; i <= 8; i++) begin
            if ({NF_CE, NF_OE, NF_WE, NF_D_OE} != 4'hE) bad++;
            @(posedge clk);
            #1;
            if (i == 7) chk("busy_after_7", {31'h0, busy}, 32'h1);
            if (i == 8) chk("busy_after_8", {31'h0, busy}, 32'h0);
        end
        chk("init_strobes_quiet", bad, 0);

        rd_val = 8'h3C;
        o0 = oe_cnt;
        n0 = done_cnt;
        issue(1'b0, 24'h0000A5, 8'h00, 8'h3C, 1'b0, 6);
        wait_done(n0, 50, "read1_done");
        chk("read1_oe_cycles", oe_cnt - o0, 4);
        chk("read1_addr", {8'h0, oe_addr}, 32'h0000A5);

        rd_val = 8'hC3;
        o0 = oe_cnt;
        n0 = done_cnt;
        issue(1'b0, 24'hFFFFFF, 8'h00, 8'hC3, 1'b0, 6);
        wait_done(n0, 50, "read2_done");
        chk("read2_oe_cycles", oe_cnt - o0, 4);
        chk("read2_addr", {8'h0, oe_addr}, 32'hFFFFFF);

        NF_STS = 1'b1;
        w0 = wr_q.size();
        n0 = done_cnt;
        issue(1'b1, 24'h000012, 8'h5A, 8'hC3, 1'b0, -1);
        repeat (3) @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        addr = 24'h000777;
        @(negedge clk);
        req = 1'b0;
        wait_writes(w0 + 2, 100);
        NF_STS = 1'b0;
        repeat (20) @(negedge clk);
        NF_STS = 1'b1;
        wait_done(n0, 200, "prog_done");
        repeat (30) @(negedge clk);
        chk("prog_single_done", done_cnt - n0, 1);
        chk("prog_write_count", wr_q.size() - w0, 3);
        if (wr_q.size() >= w0 + 3) begin
            chk("prog_w0_cmd", {24'h0, wr_q[w0]}, 32'h40);
            chk("prog_w1_data", {24'h0, wr_q[w0+1]}, 32'h5A);
            chk("prog_w2_ra", {24'h0, wr_q[w0+2]}, 32'hFF);
            for (int i = 0; i < 3; i++) begin
                chk("prog_we_width", wlen_q[w0+i], 3);
                chk("prog_addr", {8'h0, wadr_q[w0+i]}, 32'h000012);
            end
        end

        NF_STS = 1'b0;
        w0 = wr_q.size();
        n0 = done_cnt;
        issue(1'b1, 24'h800000, 8'hA5, 8'hC3, 1'b1, 1015);
        wait_done(n0, 1200, "timeout_done");
        chk("timeout_write_count", wr_q.size() - w0, 3);
        if (wr_q.size() >= w0 + 3)
            chk("timeout_ra_written", {24'h0, wr_q[w0+2]}, 32'hFF);

        w0 = wr_q.size();
        issue(1'b1, 24'h345678, 8'h11, 8'hC3, 1'b0, -1);
        wait_writes(w0 + 2, 100);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rp", {31'h0, NF_RP}, 32'h0);
        chk("abort_strobes", {28'h0, NF_CE, NF_OE, NF_WE, NF_D_OE}, 32'hE);
        chk("abort_busy", {31'h0, busy}, 32'h1);
        sb_q.delete();
        repeat (5) @(negedge clk);
        rst    = 1'b0;
        NF_STS = 1'b1;
        t = 0;
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reinit", {31'h0, busy}, 32'h0);
        chk("abort_no_ra", wr_q.size() - w0, 2);
        chk("abort_rdata_cleared", {24'h0, rdata}, 32'h0);

        rd_val = 8'h81;
        n0 = done_cnt;
        issue(1'b0, 24'h000000, 8'h00, 8'h81, 1'b0, 6);
        wait_done(n0, 50, "read3_done");

        chk("oe_doe_exclusive", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flash_ctrl.md
FLASH_CTRL -- requirements
Module: flash_ctrl

Interface
REQ-001 Parameter ADDR_W, default 24: flash byte-address width.
REQ-002 Parameter T_ACC, default 4: clk cycles NF_OE held low per read; must be >= 1.
REQ-003 Parameter T_WP, default 3: clk cycles NF_WE held low per bus write; must be >= 1.
REQ-004 Parameter T_GAP, default 2: clk cycles NF_WE held high between consecutive bus writes; must be >= 1.
REQ-005 Parameter T_RST, default 8: clk cycles after NF_RP rises before the first request is accepted.
REQ-006 Parameter TIMEOUT, default 1000: maximum clk cycles spent waiting for NF_STS.
REQ-007 Port clk, input, 1: single clock; all logic is clocked on its rising edge.
REQ-008 Port rst, input, 1: asynchronous, active-high reset.
REQ-009 Port req, input, 1: start operation; sampled only while busy=0.
REQ-010 Port we, input, 1: operation select, 0=read byte, 1=program byte; sampled with req.
REQ-011 Ports addr (input, ADDR_W) and wdata (input, 8): target address and program data; sampled with req.
REQ-012 Ports rdata (output, 8), busy (output, 1), done (output, 1, one-cycle pulse), err (output, 1, valid with done).
REQ-013 Ports NF_A (output, ADDR_W), NF_D_OUT (output, 8), NF_D_OE (output, 1), NF_D_IN (input, 8): flash bus; the tristate buffer lives at top level.
REQ-014 Ports NF_CE, NF_OE, NF_WE (outputs, 1, active low), NF_BYTE, NF_RP, NF_WP (outputs, 1), NF_STS (input, 1, 1=ready).

Function
REQ-015 NF_BYTE is constant 0 (x8 mode); NF_WP is constant 1.
REQ-016 FSM states: INIT, IDLE, RD, WR_CMD, WR_GAP, WR_DATA, WAIT_STS, WR_RA, FIN.
REQ-017 INIT: NF_RP=1; count T_RST cycles, then IDLE. busy=1 throughout INIT.
REQ-018 IDLE: busy=0; req=1 latches we/addr/wdata and moves to RD (we=0) or WR_CMD (we=1) on the next edge.
REQ-019 RD: NF_A=addr, NF_CE=0, NF_OE=0 for exactly T_ACC cycles; rdata loads NF_D_IN on the last of those cycles; then FIN.
REQ-020 WR_CMD: NF_CE=0, NF_WE=0, NF_D_OUT=0x40 for T_WP cycles, then WR_GAP.
REQ-021 WR_GAP: NF_WE=1 for T_GAP cycles, then WR_DATA (after WR_CMD) or WAIT_STS (after WR_DATA).
REQ-022 WR_DATA: NF_WE=0, NF_D_OUT=wdata for T_WP cycles, then WR_GAP.
REQ-023 NF_A holds the latched addr during every write-phase state.
REQ-024 WAIT_STS: NF_CE=1; NF_STS passes through a 2-flop synchronizer; the synchronized value is ignored for the first 2 cycles of the state.
REQ-025 WAIT_STS exits to WR_RA when the synchronized NF_STS=1 or after TIMEOUT cycles; on timeout err is set.
REQ-026 WR_RA: NF_D_OUT=0xFF (read-array command), NF_WE=0 for T_WP cycles with NF_CE=0, then FIN.
REQ-027 FIN: all strobes high; done=1 for one cycle; err valid in that cycle; then IDLE.
REQ-028 NF_D_OE=1 only in WR_CMD, WR_GAP, WR_DATA and WR_RA; NF_OE=0 and NF_D_OE=1 are never asserted together.
REQ-029 All NF_* outputs are registered (no combinational paths from inputs).
REQ-030 Read latency: done is asserted T_ACC+2 cycles after the req edge.
REQ-031 A req asserted while busy=1 is ignored and not queued.

Reset
REQ-032 On rst: state=INIT; NF_RP=0; NF_CE/NF_OE/NF_WE=1; NF_D_OE=0; NF_A=0; NF_D_OUT=0; rdata=0; done=0; err=0; busy=1; all counters=0.
REQ-033 Reset asserted mid-operation aborts immediately to the reset values above; no read-array command is issued.

Structure
REQ-034 A shared package holds the FSM state encoding and the flash command constants (0x40 program, 0xFF read array).
REQ-035 One sub-module, flash_sync2: a 2-flop synchronizer with asynchronous reset, used for NF_STS.

Verification
REQ-036 Reset release -> NF_RP=1 in the first cycle; busy=0 after T_RST=8 cycles; no strobe activity before then.
REQ-037 Read, addr=0x0000A5, model drives 0x3C -> NF_OE low exactly 4 cycles; rdata=0x3C; done 6 cycles after req; err=0.
REQ-038 Program, addr=0x12, wdata=0x5A, NF_STS high after 20 cycles -> bus writes 0x40, 0x5A, 0xFF observed by the flash model; each NF_WE low pulse is 3 cycles; err=0.
REQ-039 Program with NF_STS held 0, TIMEOUT=1000 -> done with err=1 after the 1000-cycle wait; 0xFF is still written.
REQ-040 req pulsed during a busy program -> ignored; exactly one done is produced.
REQ-041 rst asserted during WAIT_STS -> all strobes high and NF_RP=0 immediately; no 0xFF is written.
